// File: rtl/sata_tx_crc.sv
// SATA transmit CRC stage: passes local-link frames to the link layer and appends the frame CRC dword.
// Optional scrambler enabled by defining TXCRC_SCRAMBLE_EN (default build: unscrambled output).
module sata_tx_crc (
    input  logic        phyclk,
    input  logic        phyreset,
    input  logic [31:0] trn_td,
    input  logic        trn_tsof_n,
    input  logic        trn_teof_n,
    input  logic        trn_tsrc_rdy_n,
    input  logic        trn_tsrc_dsc_n,
    output logic        trn_tdst_rdy_n,
    output logic        trn_tdst_dsc_n,
    output logic [31:0] tx_data,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        err_sof
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_DATA  = 2'd1;
    localparam logic [1:0]  ST_CRC   = 2'd2;
    localparam logic [31:0] CRC_SEED = 32'h52325032;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

    // One dword through the MSB-first, unreflected CRC-32.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            if (r[31] ^ d[i])
                r = {r[30:0], 1'b0} ^ CRC_POLY;
            else
                r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    logic [1:0]  state_reg;
    logic [31:0] crc_reg;
    logic        abort_reg;
    logic [31:0] tx_data_reg;
    logic        tx_sof_reg;
    logic        tx_eof_reg;
    logic        tx_valid_reg;
    logic        err_sof_reg;

    logic        slot_free;
    logic        up_xfer;
    logic        start_word;
    logic        end_word;
    logic        crc_load;
    logic [31:0] crc_base;
    logic [31:0] crc_next;
    logic [31:0] crc_out;
    logic [31:0] scr_mask;
    logic [31:0] word_out;

    assign slot_free  = !tx_valid_reg || tx_ready;
    assign up_xfer    = !trn_tdst_rdy_n && !trn_tsrc_rdy_n;
    assign start_word = up_xfer && !trn_tsof_n;
    // A discontinue inside a frame closes it just like an eof word.
    assign end_word   = !trn_teof_n || (!trn_tsrc_dsc_n && (state_reg == ST_DATA));
    assign crc_load   = (state_reg == ST_CRC) && slot_free;
    assign crc_base   = start_word ? CRC_SEED : crc_reg;
    assign crc_next   = crc_step(crc_base, trn_td);
    assign crc_out    = abort_reg ? ~crc_reg : crc_reg;
    assign word_out   = ((state_reg == ST_CRC) ? crc_out : trn_td) ^ scr_mask;

`ifdef TXCRC_SCRAMBLE_EN
    localparam logic [15:0] LFSR_SEED = 16'hF0F6;

    // 32 serial steps of x^16+x^15+x^13+x^4+1; result is {next_state, mask}.
    function automatic logic [47:0] lfsr_run(input logic [15:0] s);
        logic [15:0] st;
        logic [31:0] m;
        st = s;
        m  = '0;
        for (int i = 0; i < 32; i++) begin
            m[i] = st[15];
            st   = {st[14:0], st[15] ^ st[14] ^ st[12] ^ st[3]};
        end
        return {st, m};
    endfunction

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_base;
    logic [15:0] lfsr_adv;
    logic        word_load;

    assign lfsr_base            = start_word ? LFSR_SEED : lfsr_reg;
    assign {lfsr_adv, scr_mask} = lfsr_run(lfsr_base);
    // Every loaded word is transferred exactly once, so stepping on load is stepping per transfer.
    assign word_load            = (up_xfer && (state_reg == ST_DATA || !trn_tsof_n)) || crc_load;

    always_ff @(posedge phyclk) begin
        if (phyreset)
            lfsr_reg <= LFSR_SEED;
        else if (word_load)
            lfsr_reg <= lfsr_adv;
    end
`else
    assign scr_mask = '0;
`endif

    assign trn_tdst_rdy_n = !((state_reg != ST_CRC) && slot_free && !phyreset);
    assign trn_tdst_dsc_n = 1'b1;
    assign tx_data        = tx_data_reg;
    assign tx_sof         = tx_sof_reg;
    assign tx_eof         = tx_eof_reg;
    assign tx_valid       = tx_valid_reg;
    assign err_sof        = err_sof_reg;

    always_ff @(posedge phyclk) begin
        if (phyreset) begin
            state_reg    <= ST_IDLE;
            crc_reg      <= CRC_SEED;
            abort_reg    <= 1'b0;
            tx_data_reg  <= '0;
            tx_sof_reg   <= 1'b0;
            tx_eof_reg   <= 1'b0;
            tx_valid_reg <= 1'b0;
            err_sof_reg  <= 1'b0;
        end else begin
            err_sof_reg <= 1'b0;
            if (tx_valid_reg && tx_ready)
                tx_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_word) begin
                        crc_reg      <= crc_next;
                        tx_data_reg  <= word_out;
                        tx_sof_reg   <= 1'b1;
                        tx_eof_reg   <= 1'b0;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= end_word ? ST_CRC : ST_DATA;
                    end else if (up_xfer) begin
                        err_sof_reg <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (up_xfer) begin
                        // An unexpected sof restarts the frame from a fresh seed.
                        crc_reg      <= crc_next;
                        tx_data_reg  <= word_out;
                        tx_sof_reg   <= !trn_tsof_n;
                        tx_eof_reg   <= 1'b0;
                        tx_valid_reg <= 1'b1;
                        err_sof_reg  <= !trn_tsof_n;
                        if (!trn_tsrc_dsc_n)
                            abort_reg <= 1'b1;
                        if (end_word)
                            state_reg <= ST_CRC;
                    end
                end
                ST_CRC: begin
                    if (crc_load) begin
                        tx_data_reg  <= word_out;
                        tx_sof_reg   <= 1'b0;
                        tx_eof_reg   <= 1'b1;
                        tx_valid_reg <= 1'b1;
                        abort_reg    <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sata_tx_crc.sv
// Directed bench for sata_tx_crc: vector table for single-cycle behaviour, hand sequences for
// backpressure and mid-frame reset. Define TXCRC_SCRAMBLE_EN to check the scrambled build.
module tb_sata_tx_crc;

    localparam logic [31:0] SEED = 32'h52325032;

    logic        phyclk = 1'b0;
    logic        phyreset;
    logic [31:0] trn_td;
    logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
    logic        trn_tdst_rdy_n, trn_tdst_dsc_n;
    logic [31:0] tx_data;
    logic        tx_sof, tx_eof, tx_valid, tx_ready, err_sof;

    always #5 phyclk = ~phyclk;

    sata_tx_crc dut (
        .phyclk         (phyclk),
        .phyreset       (phyreset),
        .trn_td         (trn_td),
        .trn_tsof_n     (trn_tsof_n),
        .trn_teof_n     (trn_teof_n),
        .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
        .trn_tsrc_dsc_n (trn_tsrc_dsc_n),
        .trn_tdst_rdy_n (trn_tdst_rdy_n),
        .trn_tdst_dsc_n (trn_tdst_dsc_n),
        .tx_data        (tx_data),
        .tx_sof         (tx_sof),
        .tx_eof         (tx_eof),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .err_sof        (err_sof)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference CRC: fold the dword into the register, then shift it out 32 times.
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c ^ d;
        for (int i = 0; i < 32; i++)
            r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        return r;
    endfunction

`ifdef TXCRC_SCRAMBLE_EN
    logic [15:0] m_lfsr = 16'hF0F6;
`endif

    // Expected wire value of the next emitted dword (scrambled when the scrambler is built in).
    function automatic logic [31:0] sx(input logic [31:0] w, input bit sof);
        logic [31:0] m;
        m = '0;
`ifdef TXCRC_SCRAMBLE_EN
        begin
            logic [15:0] st;
            st = sof ? 16'hF0F6 : m_lfsr;
            for (int i = 0; i < 32; i++) begin
                m[i] = st[15];
                st   = {st[14:0], st[15] ^ st[14] ^ st[12] ^ st[3]};
            end
            m_lfsr = st;
        end
`endif
        return w ^ m;
    endfunction

    typedef struct {
        logic [31:0] td;
        logic        sof_n, eof_n, src_rdy_n, dsc_n;
        logic        exp_rdy_n, exp_valid, exp_sof, exp_eof, exp_err;
        logic [31:0] exp_data;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] td, input logic sof_n, input logic eof_n,
                                input logic src_rdy_n, input logic dsc_n, input logic exp_rdy_n,
                                input logic ev, input logic es, input logic ee, input logic er,
                                input logic [31:0] ed);
        vec_t v;
        v.td = td; v.sof_n = sof_n; v.eof_n = eof_n; v.src_rdy_n = src_rdy_n; v.dsc_n = dsc_n;
        v.exp_rdy_n = exp_rdy_n; v.exp_valid = ev; v.exp_sof = es; v.exp_eof = ee;
        v.exp_err = er; v.exp_data = ed;
        return v;
    endfunction

    vec_t        tbl[$];
    logic [31:0] c;
    logic [31:0] bw [4];
    logic [31:0] bexp [5];

    initial begin
        phyreset = 1'b1; tx_ready = 1'b1;
        trn_td = '0; trn_tsof_n = 1'b1; trn_teof_n = 1'b1; trn_tsrc_rdy_n = 1'b1; trn_tsrc_dsc_n = 1'b1;

        // Three-word frame 1,2,3 then CRC; next frame follows with no bubble.
        c = crc_upd(crc_upd(crc_upd(SEED, 32'h1), 32'h2), 32'h3);
        tbl.push_back(mk(32'h1, 0, 1, 0, 1, 0, 1, 1, 0, 0, sx(32'h1, 1)));
        tbl.push_back(mk(32'h2, 1, 1, 0, 1, 0, 1, 0, 0, 0, sx(32'h2, 0)));
        tbl.push_back(mk(32'h3, 1, 0, 0, 1, 0, 1, 0, 0, 0, sx(32'h3, 0)));
        tbl.push_back(mk(32'h0, 1, 1, 1, 1, 1, 1, 0, 1, 0, sx(c, 0)));
        // Single-dword frame: upstream stalled for exactly one cycle.
        tbl.push_back(mk(32'hDEADBEEF, 0, 0, 0, 1, 0, 1, 1, 0, 0, sx(32'hDEADBEEF, 1)));
        tbl.push_back(mk(32'h0, 1, 1, 1, 1, 1, 1, 0, 1, 0, sx(crc_upd(SEED, 32'hDEADBEEF), 0)));
        tbl.push_back(mk(32'h0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 32'h0));
        // Word without sof in IDLE is dropped with a single err_sof pulse.
        tbl.push_back(mk(32'h11, 1, 1, 0, 1, 0, 0, 0, 0, 1, 32'h0));
        tbl.push_back(mk(32'h0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 32'h0));
        c = crc_upd(crc_upd(SEED, 32'hA5A5A5A5), 32'h5A5A5A5A);
        tbl.push_back(mk(32'hA5A5A5A5, 0, 1, 0, 1, 0, 1, 1, 0, 0, sx(32'hA5A5A5A5, 1)));
        tbl.push_back(mk(32'h5A5A5A5A, 1, 0, 0, 1, 0, 1, 0, 0, 0, sx(32'h5A5A5A5A, 0)));
        tbl.push_back(mk(32'h0, 1, 1, 1, 1, 1, 1, 0, 1, 0, sx(c, 0)));
        // sof inside a frame restarts it.
        c = crc_upd(crc_upd(SEED, 32'h200), 32'h300);
        tbl.push_back(mk(32'h100, 0, 1, 0, 1, 0, 1, 1, 0, 0, sx(32'h100, 1)));
        tbl.push_back(mk(32'h200, 0, 1, 0, 1, 0, 1, 1, 0, 1, sx(32'h200, 1)));
        tbl.push_back(mk(32'h300, 1, 0, 0, 1, 0, 1, 0, 0, 0, sx(32'h300, 0)));
        tbl.push_back(mk(32'h0, 1, 1, 1, 1, 1, 1, 0, 1, 0, sx(c, 0)));
        // Discontinue on 2nd word: inverted CRC, then a clean frame proves abort cleared.
        c = crc_upd(crc_upd(SEED, 32'h10), 32'h20);
        tbl.push_back(mk(32'h10, 0, 1, 0, 1, 0, 1, 1, 0, 0, sx(32'h10, 1)));
        tbl.push_back(mk(32'h20, 1, 1, 0, 0, 0, 1, 0, 0, 0, sx(32'h20, 0)));
        tbl.push_back(mk(32'h0, 1, 1, 1, 1, 1, 1, 0, 1, 0, sx(~c, 0)));
        tbl.push_back(mk(32'h33, 0, 0, 0, 1, 0, 1, 1, 0, 0, sx(32'h33, 1)));
        tbl.push_back(mk(32'h0, 1, 1, 1, 1, 1, 1, 0, 1, 0, sx(crc_upd(SEED, 32'h33), 0)));
        tbl.push_back(mk(32'h0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 32'h0));

        // Reset state.
        @(negedge phyclk);
        chk1("reset_rdy_n", trn_tdst_rdy_n, 1'b1);
        chk1("reset_dst_dsc_n", trn_tdst_dsc_n, 1'b1);
        @(posedge phyclk); #1;
        chk1("reset_valid", tx_valid, 1'b0);
        chk1("reset_sof", tx_sof, 1'b0);
        chk1("reset_eof", tx_eof, 1'b0);
        chk1("reset_err", err_sof, 1'b0);
        chk("reset_data", tx_data, 32'h0);
        phyreset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            trn_td = tbl[i].td; trn_tsof_n = tbl[i].sof_n; trn_teof_n = tbl[i].eof_n;
            trn_tsrc_rdy_n = tbl[i].src_rdy_n; trn_tsrc_dsc_n = tbl[i].dsc_n;
            @(negedge phyclk);
            chk1($sformatf("row%0d_rdy_n", i), trn_tdst_rdy_n, tbl[i].exp_rdy_n);
            @(posedge phyclk); #1;
            $display("row %0d: td=%h valid=%b sof=%b eof=%b err=%b data=%h", i, tbl[i].td,
                     tx_valid, tx_sof, tx_eof, err_sof, tx_data);
            chk1($sformatf("row%0d_valid", i), tx_valid, tbl[i].exp_valid);
            chk1($sformatf("row%0d_err", i), err_sof, tbl[i].exp_err);
            if (tbl[i].exp_valid) begin
                chk1($sformatf("row%0d_sof", i), tx_sof, tbl[i].exp_sof);
                chk1($sformatf("row%0d_eof", i), tx_eof, tbl[i].exp_eof);
                chk($sformatf("row%0d_data", i), tx_data, tbl[i].exp_data);
            end
        end

        // Backpressure: tx_ready 1010... across a 4-word frame.
        bw[0] = 32'hCAFE0001; bw[1] = 32'hCAFE0002; bw[2] = 32'hCAFE0003; bw[3] = 32'hCAFE0004;
        c = SEED;
        for (int i = 0; i < 4; i++) begin
            c = crc_upd(c, bw[i]);
            bexp[i] = sx(bw[i], i == 0);
        end
        bexp[4] = sx(c, 0);
        trn_tsrc_dsc_n = 1'b1;
        begin
            int          sent, got;
            logic        held;
            logic [31:0] snap_data;
            logic        snap_sof, snap_eof;
            sent = 0; got = 0; held = 1'b0;
            snap_data = '0; snap_sof = 1'b0; snap_eof = 1'b0;
            for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
                tx_ready = (cyc % 2 == 0);
                if (sent < 4) begin
                    trn_td = bw[sent]; trn_tsof_n = (sent != 0); trn_teof_n = (sent != 3);
                    trn_tsrc_rdy_n = 1'b0;
                end else begin
                    trn_tsrc_rdy_n = 1'b1;
                end
                @(negedge phyclk);
                if (held) begin
                    chk1("bp_hold_valid", tx_valid, 1'b1);
                    chk("bp_hold_data", tx_data, snap_data);
                    chk1("bp_hold_sof", tx_sof, snap_sof);
                    chk1("bp_hold_eof", tx_eof, snap_eof);
                end
                if (!trn_tdst_rdy_n && !trn_tsrc_rdy_n)
                    sent++;
                if (tx_valid && tx_ready) begin
                    $display("bp out %0d: data=%h sof=%b eof=%b", got, tx_data, tx_sof, tx_eof);
                    chk($sformatf("bp_data%0d", got), tx_data, bexp[got]);
                    chk1($sformatf("bp_sof%0d", got), tx_sof, got == 0);
                    chk1($sformatf("bp_eof%0d", got), tx_eof, got == 4);
                    got++;
                end
                held = tx_valid && !tx_ready;
                snap_data = tx_data; snap_sof = tx_sof; snap_eof = tx_eof;
                @(posedge phyclk); #1;
            end
            chk("bp_words_out", got, 5);
            chk("bp_words_in", sent, 4);
        end
        tx_ready = 1'b1; trn_tsrc_rdy_n = 1'b1;
        @(posedge phyclk); #1;

        // Reset in the middle of a frame.
        trn_td = 32'h77; trn_tsof_n = 1'b0; trn_teof_n = 1'b1; trn_tsrc_rdy_n = 1'b0;
        @(posedge phyclk); #1;
        trn_td = 32'h88; trn_tsof_n = 1'b1;
        @(posedge phyclk); #1;
        phyreset = 1'b1; trn_tsrc_rdy_n = 1'b1;
        @(negedge phyclk);
        chk1("rst_rdy_n", trn_tdst_rdy_n, 1'b1);
        @(posedge phyclk); #1;
        $display("mid-frame reset: valid=%b data=%h", tx_valid, tx_data);
        chk1("rst_valid", tx_valid, 1'b0);
        chk("rst_data", tx_data, 32'h0);
        chk1("rst_eof", tx_eof, 1'b0);
        phyreset = 1'b0;
        @(posedge phyclk); #1;
        chk1("rst_no_crc", tx_valid, 1'b0);
        trn_td = 32'h12345678; trn_tsof_n = 1'b0; trn_teof_n = 1'b0; trn_tsrc_rdy_n = 1'b0;
        @(posedge phyclk); #1;
        trn_tsrc_rdy_n = 1'b1;
        $display("post-reset sof: data=%h sof=%b", tx_data, tx_sof);
        chk1("rst_new_sof", tx_sof, 1'b1);
        chk("rst_first_data", tx_data, sx(32'h12345678, 1));
        @(posedge phyclk); #1;
        $display("post-reset crc: data=%h eof=%b", tx_data, tx_eof);
        chk1("rst_crc_eof", tx_eof, 1'b1);
        chk("rst_crc_data", tx_data, sx(crc_upd(SEED, 32'h12345678), 0));
        @(posedge phyclk); #1;
        chk1("rst_end_valid", tx_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sata_tx_crc.md
SATA_TX_CRC -- requirements
Module: sata_tx_crc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows, clock and reset first:
- phyclk  in  1  clock for all logic
- phyreset  in  1  synchronous active-high reset
- trn_td  in  32  upstream local-link data
- trn_tsof_n  in  1  start of frame, active low
- trn_teof_n  in  1  end of frame, active low
- trn_tsrc_rdy_n  in  1  upstream word valid, active low
- trn_tsrc_dsc_n  in  1  upstream discontinue, active low
- trn_tdst_rdy_n  out  1  block accepts word, active low
- trn_tdst_dsc_n  out  1  tied 1
- tx_data  out  32  dword toward the link layer
- tx_sof  out  1  first dword of frame
- tx_eof  out  1  CRC dword (last of frame)
- tx_valid  out  1  tx_* valid
- tx_ready  in  1  link layer accepts tx_*
- err_sof  out  1  one-cycle pulse, framing error

Function
REQ-003 An upstream transfer SHALL occur when trn_tsrc_rdy_n=0 and trn_tdst_rdy_n=0 in the same cycle; a downstream transfer SHALL occur when tx_valid=1 and tx_ready=1.
REQ-004 The output register SHALL be a single stage; tx_* SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-005 trn_tdst_rdy_n SHALL be 0 only when state is not CRC and either tx_valid=0 or tx_ready=1.
REQ-006 The FSM SHALL have three states: IDLE, DATA and CRC.
REQ-007 IDLE with a transfer and tsof_n=0 SHALL cause the following:
- CRC loads seed 0x52325032, then advances over trn_td.
- The output register is loaded with tx_sof=1.
- Next state is CRC if teof_n=0 in the same word, else DATA.
REQ-008 IDLE with a transfer and tsof_n=1 SHALL drop the word, pulse err_sof, and stay in IDLE.
REQ-009 DATA with a transfer SHALL advance the CRC, load the word with tx_sof=0, and go to CRC on teof_n=0.
REQ-010 DATA with a transfer and tsof_n=0 SHALL pulse err_sof and restart the frame: reseed the CRC and output the word with tx_sof=1.
REQ-011 A trn_tsrc_dsc_n=0 transfer in DATA SHALL set an abort flag, and the word SHALL be treated as the eof word.
REQ-012 In CRC, when the output slot frees, the block SHALL load tx_data=CRC (bitwise inverted if the abort flag is set) with tx_eof=1, then go to IDLE and clear the abort flag.
REQ-013 The CRC SHALL use polynomial 0x04C11DB7, dword-parallel, MSB-first, unreflected, with no final XOR, computed over unscrambled data.
REQ-014 Latency SHALL be one cycle from upstream acceptance to tx_valid; with tx_ready held at 1, each N-dword frame SHALL occupy N+1 output cycles and the stream SHALL have zero bubbles except the one upstream stall cycle per frame (CRC slot).
REQ-015 tx_eof SHALL be asserted only on the CRC dword, and upstream eof SHALL never be forwarded.

Reset
REQ-016 phyreset=1 on a clock edge SHALL force the following, regardless of FSM state, including mid-frame:
- state=IDLE
- tx_valid=0, tx_sof=0, tx_eof=0, tx_data=0
- err_sof=0
- abort flag cleared
- CRC register=0x52325032
REQ-017 During reset, trn_tdst_rdy_n SHALL be 1.
REQ-018 A frame interrupted by reset SHALL be discarded with no CRC dword emitted.

Configuration
REQ-019 Defining TXCRC_SCRAMBLE_EN SHALL enable the SATA scrambler, as follows:
- Each tx_data dword (data and CRC) is XORed with the output of a 16-bit LFSR (x^16+x^15+x^13+x^4+1) producing 32 bits per step.
- The LFSR is reseeded to 0xF0F6 on every sof word.
- The LFSR advances once per downstream transfer.
REQ-020 Without TXCRC_SCRAMBLE_EN, tx_data SHALL carry unscrambled data and CRC, and no LFSR logic SHALL be present.

Verification
REQ-021 Single frame, tx_ready=1: send sof word 0x00000001, middle word 0x00000002, eof word 0x00000003 -> tx outputs 1,2,3 then the CRC dword, which must equal the golden software CRC; tx_sof only on 0x1, tx_eof only on CRC.
REQ-022 Single-dword frame (sof=eof=0, data 0xDEADBEEF) -> 2 output dwords; trn_tdst_rdy_n=1 for exactly one cycle.
REQ-023 Backpressure: tx_ready toggles 1010 during a 4-word frame -> no data lost or duplicated; tx_* stable while stalled.
REQ-024 Word without sof in IDLE -> dropped; err_sof pulses once; the next proper frame is correct.
REQ-025 Discontinue on the 2nd word of a 3-word frame -> 2 data dwords, then the inverted golden CRC with tx_eof=1; the FSM returns to IDLE.
REQ-026 Reset asserted during DATA -> tx_valid=0 next cycle; the following frame uses a fresh seed. If TXCRC_SCRAMBLE_EN is defined, also check the first scrambled dword against the golden LFSR output for seed 0xF0F6.
